// File: rtl/mips_enc_pkg.sv
// Mnemonic codes, MIPS opcode/funct constants and field-selection helpers shared by the encoder.
// Optional field checking is enabled by defining MIPS_ENC_CHECK_EN.
package mips_enc_pkg;

  localparam int NUM_MNEM = 20;

  typedef enum logic [4:0] {
    M_ADD  = 5'd0,
    M_SUB  = 5'd1,
    M_AND  = 5'd2,
    M_OR   = 5'd3,
    M_XOR  = 5'd4,
    M_SLL  = 5'd5,
    M_SRL  = 5'd6,
    M_SRA  = 5'd7,
    M_JR   = 5'd8,
    M_ADDI = 5'd9,
    M_ANDI = 5'd10,
    M_ORI  = 5'd11,
    M_XORI = 5'd12,
    M_LW   = 5'd13,
    M_SW   = 5'd14,
    M_BEQ  = 5'd15,
    M_BNE  = 5'd16,
    M_LUI  = 5'd17,
    M_J    = 5'd18,
    M_JAL  = 5'd19
  } mnem_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  function automatic logic [5:0] rtype_funct(input logic [4:0] m);
    logic [5:0] f;
    f = FN_ADD;
    case (m)
      M_SUB:   f = FN_SUB;
      M_AND:   f = FN_AND;
      M_OR:    f = FN_OR;
      M_XOR:   f = FN_XOR;
      M_SLL:   f = FN_SLL;
      M_SRL:   f = FN_SRL;
      M_SRA:   f = FN_SRA;
      M_JR:    f = FN_JR;
      default: f = FN_ADD;
    endcase
    return f;
  endfunction

  // Opcode for I- and J-type mnemonics; R-type and illegal codes yield OP_R.
  function automatic logic [5:0] major_opcode(input logic [4:0] m);
    logic [5:0] op;
    op = OP_R;
    case (m)
      M_ADDI:  op = OP_ADDI;
      M_ANDI:  op = OP_ANDI;
      M_ORI:   op = OP_ORI;
      M_XORI:  op = OP_XORI;
      M_LW:    op = OP_LW;
      M_SW:    op = OP_SW;
      M_BEQ:   op = OP_BEQ;
      M_BNE:   op = OP_BNE;
      M_LUI:   op = OP_LUI;
      M_J:     op = OP_J;
      M_JAL:   op = OP_JAL;
      default: op = OP_R;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// Request/response bundle of the instruction encoder: encode request in, addressed word stream out.
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, mnem, rs, rt, rd, shamt, imm, target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, mnem, rs, rt, rd, shamt, imm, target, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/mips_instr_encoder_enc_fifo.sv
// Synchronous FIFO with combinational head read; full/empty come from an occupancy count.
// flush empties it synchronously and has priority over push/pop.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr_reg];

  // Storage carries no reset: the head is masked by the encoder whenever empty is set.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Builds 32-bit MIPS words from mnemonic + operand fields and queues them with word addresses.
// Define MIPS_ENC_CHECK_EN to reject requests with non-zero unused fields instead of zeroing them.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  flush,
  mips_instr_encoder_if.slave   bus,
  output logic                  err,
  output logic [7:0]            err_cnt
);
  localparam int ENTRY_W = ADDR_W + 32;

  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] head;
  logic [31:0]        enc_word;
  logic               mnem_ok;
  logic               req_ok;
  logic               accept;
  logic               push;
  logic               drop;
  logic               pop;
  logic [ADDR_W-1:0]  push_addr_reg;
  logic [ADDR_W-1:0]  pop_addr_reg;
  logic               err_reg;
  logic [7:0]         err_cnt_reg;

  always_comb begin
    enc_word = '0;
    mnem_ok  = 1'b1;
    case (bus.mnem)
      M_ADD, M_SUB, M_AND, M_OR, M_XOR:
        enc_word = {OP_R, bus.rs, bus.rt, bus.rd, 5'd0, rtype_funct(bus.mnem)};
      M_SLL, M_SRL, M_SRA:
        enc_word = {OP_R, 5'd0, bus.rt, bus.rd, bus.shamt, rtype_funct(bus.mnem)};
      M_JR:
        enc_word = {OP_R, bus.rs, 15'd0, FN_JR};
      M_ADDI, M_ANDI, M_ORI, M_XORI, M_LW, M_SW, M_BEQ, M_BNE:
        enc_word = {major_opcode(bus.mnem), bus.rs, bus.rt, bus.imm};
      M_LUI:
        enc_word = {OP_LUI, 5'd0, bus.rt, bus.imm};
      M_J, M_JAL:
        enc_word = {major_opcode(bus.mnem), bus.target};
      default:
        mnem_ok = 1'b0;
    endcase
  end

`ifdef MIPS_ENC_CHECK_EN
  logic field_bad;

  always_comb begin
    field_bad = 1'b0;
    case (bus.mnem)
      M_ADD, M_SUB, M_AND, M_OR, M_XOR: field_bad = (bus.shamt != 5'd0);
      M_SLL, M_SRL, M_SRA:              field_bad = (bus.rs != 5'd0);
      M_LUI:                            field_bad = (bus.rs != 5'd0);
      M_JR:                             field_bad = |{bus.rt, bus.rd, bus.shamt};
      default:                          field_bad = 1'b0;
    endcase
  end

  assign req_ok = mnem_ok & ~field_bad;
`else
  assign req_ok = mnem_ok;
`endif

  // Rejected requests are still handshaken so the producer never stalls on a bad code.
  assign accept = bus.in_valid & ~full;
  assign push   = accept & req_ok & ~flush;
  assign drop   = accept & ~req_ok & ~flush;
  assign pop    = bus.out_ready & ~empty & ~flush;

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .flush (flush),
    .push  (push),
    .din   ({push_addr_reg, enc_word}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_instr = empty ? 32'd0 : head[31:0];
  // When nothing is queued, show the address the next popped word will carry.
  assign bus.out_addr  = empty ? pop_addr_reg : head[ENTRY_W-1:32];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      push_addr_reg <= ADDR_W'(BASE_ADDR);
      pop_addr_reg  <= ADDR_W'(BASE_ADDR);
    end else if (flush) begin
      push_addr_reg <= ADDR_W'(BASE_ADDR);
      pop_addr_reg  <= ADDR_W'(BASE_ADDR);
    end else begin
      if (push) begin
        push_addr_reg <= push_addr_reg + ADDR_W'(1);
      end
      if (pop) begin
        pop_addr_reg <= pop_addr_reg + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      err_reg     <= 1'b0;
      err_cnt_reg <= 8'd0;
    end else if (flush) begin
      err_reg     <= 1'b0;
      err_cnt_reg <= 8'd0;
    end else if (drop) begin
      err_reg <= 1'b1;
      if (err_cnt_reg != 8'hFF) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
    end
  end

  assign err     = err_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the single-cycle control decoder: takes a mnemonic code plus operand fields and produces the 32-bit MIPS instruction word.
- Words are queued in an internal FIFO and streamed out with a word address, so a loader can program instruction memory.
- Covers the same 20-instruction subset the CPU decodes.
- Used by test benches and a boot loader to build programs in hardware.

Parameters:
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- ADDR_W, 8: width of the word-address counter.
- BASE_ADDR, 0: word address assigned to the first emitted instruction.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear: empties FIFO, reloads address, clears error state.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- mnem  in  5  mnemonic code (see package).
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- imm  in  16  immediate / branch offset.
- target  in  26  jump target field.
- out_valid  out  1  an encoded word is available.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_W  word address of out_instr.
- err  out  1  sticky; set on any dropped request.
- err_cnt  out  8  number of dropped requests; saturates at 255.

Behaviour:
- Reset (clrn=0, async): FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_cnt=0.
- Handshakes:
  - in_ready = ~full. A request is accepted when in_valid & in_ready.
  - Pop occurs when out_valid & out_ready. out_valid = ~empty.
- Latency: an accepted word is visible on out_instr in the cycle after acceptance (encode and FIFO write are registered in one stage).
- Word format by class:
  - R-type: {6'b0, rs, rt, rd, shamt, funct}.
  - Shifts sll/srl/sra: rs field = 0.
  - jr: {6'b0, rs, 15'b0, 6'b001000}.
  - I-type: {op, rs, rt, imm}; lui forces rs = 0.
  - J-type: {op, target}.
- Mnemonic codes: add 0, sub 1, and 2, or 3, xor 4, sll 5, srl 6, sra 7, jr 8, addi 9, andi 10, ori 11, xori 12, lw 13, sw 14, beq 15, bne 16, lui 17, j 18, jal 19.
- Illegal mnemonic (20–31):
  - Request is still handshaken (in_ready unaffected) but nothing is written to the FIFO.
  - err is set; err_cnt increments.
- out_addr:
  - Increments by 1 on each pop and wraps modulo 2^ADDR_W.
  - Each FIFO entry stores its address, so out_addr always matches the word at the head.
  - Address is allocated at push time from a push counter seeded with BASE_ADDR.
- Full FIFO with a simultaneous pop: in_ready stays 0 that cycle (no bypass); a new push is possible the next cycle.
- Push and pop in the same cycle with FIFO neither empty nor full: both occur and occupancy is unchanged.
- Wrap: FIFO pointers wrap modulo DEPTH; full/empty are derived from an occupancy count.
- flush:
  - Has priority over push and pop in the same cycle.
  - Resets FIFO, both address counters and err/err_cnt; an accepted request in that cycle is discarded.
  - Async reset mid-stream discards all queued words immediately.

Optional Feature:
- Macro: MIPS_ENC_CHECK_EN.
- Defined: the request is rejected (dropped, err set, err_cnt incremented) if any of these hold:
  - non-shift R-type with shamt≠0;
  - shift with rs≠0;
  - lui with rs≠0;
  - jr with rt, rd or shamt ≠0.
- Undefined: those unused fields are silently forced to zero in the word; only illegal mnemonics are errors.

Decomposition:
- Package mips_enc_pkg holds:
  - mnemonic code constants (0–19);
  - opcode constants: R 000000, addi 001000, andi 001100, ori 001101, xori 001110, lw 100011, sw 101011, beq 000100, bne 000101, lui 001111, j 000010, jal 000011;
  - funct constants: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000.
- One sub-module: enc_fifo, a synchronous FIFO of {ADDR_W+32}-bit entries with parameter DEPTH, push/pop/flush, full/empty.
- Encoding logic is combinational inside mips_instr_encoder.

Test Plan:
- add (mnem 0) rs=1 rt=2 rd=3 → out_instr=0x00221820 one cycle later, out_addr=0.
- addi (9) rs=0 rt=1 imm=5, then sw (14) rs=29 rt=2 imm=4 → 0x20010005 @0, then 0xAFA20004 @1.
- j (18) target=0x10 with out_ready=0 held → out_valid stays 1, word 0x08000010 stable; after DEPTH accepts, in_ready=0; release out_ready → entries drain in order.
- mnem=25 → no output, err=1, err_cnt=1; a following add still encodes correctly.
- ADDR_W=2, six words pushed → out_addr sequence 0,1,2,3,0,1; flush mid-stream → out_valid=0 next cycle, next word at BASE_ADDR.
- With MIPS_ENC_CHECK_EN: add with shamt=3 → dropped, err_cnt increments. Without it: word 0x00221820 (shamt forced to 0).
